scan_selector: RTL and testbench
================================

SCAN_SELECTOR -- requirements
Module: scan_selector

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4, giving the number of multiplexed digits (legal range 2..8).
REQ-002 The block SHALL have parameter DIGIT_W, default 4, giving the bits per digit.
REQ-003 The block SHALL have parameter SCAN_DIV, default 50000, giving the S_CLK cycles each digit is lit (legal value ≥2).
REQ-004 The block SHALL have parameter BLANK_CYC, default 8, giving the all-off cycles between digits (legal value ≥1).
REQ-005 The block SHALL have port S_CLK, input, width 1: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port RST_N, input, width 1: the reset, asynchronous and active-low.
REQ-007 The block SHALL have port CNT_BUS, input, width NUM_DIGITS*DIGIT_W: digit values; digit i is at bits [i*DIGIT_W +: DIGIT_W], and digit 0 is the least significant.
REQ-008 The block SHALL have port DIGIT_EN, input, width NUM_DIGITS: per-digit scan enable.
REQ-009 The block SHALL have port LOAD, input, width 1: while high, CNT_BUS is sampled into the shadow register.
REQ-010 The block SHALL have port CNT, output, width DIGIT_W: the value of the lit digit, registered.
REQ-011 The block SHALL have port AN, output, width NUM_DIGITS: active-low one-hot anode select, registered.
REQ-012 The block SHALL have port SEL, output, width clog2(NUM_DIGITS): the current digit index.
REQ-013 The block SHALL have port FRAME_DONE, output, width 1: a one-cycle pulse at frame wrap.

Function
REQ-014 The FSM SHALL have exactly two states, BLANK and SHOW, and SHALL use a prescaler counter that counts 0..SCAN_DIV-1 in SHOW and 0..BLANK_CYC-1 in BLANK.
REQ-015 In BLANK, AN SHALL be all ones; after BLANK_CYC cycles the FSM SHALL enter SHOW.
REQ-016 In SHOW, AN[SEL] SHALL be 0, all other AN bits 1, and CNT = active[SEL]; after SCAN_DIV cycles the FSM SHALL advance SEL and enter BLANK.
REQ-017 SEL SHALL advance to the next index with DIGIT_EN set, searching upward modulo NUM_DIGITS; a single enabled digit SHALL re-select itself.
REQ-018 FRAME_DONE SHALL pulse for exactly one cycle when an advance yields a new SEL ≤ the old SEL (wrap).
REQ-019 On a FRAME_DONE cycle, active SHALL be loaded from shadow, so that display data never tears mid-frame.
REQ-020 When LOAD and FRAME_DONE coincide, active SHALL take the old shadow and shadow SHALL take CNT_BUS, which is displayed from the next frame.
REQ-021 When DIGIT_EN is all zero, the FSM SHALL hold BLANK, AN SHALL stay all ones, the prescaler SHALL be held at 0, and FRAME_DONE SHALL stay 0; scanning SHALL resume at the next enabled index when any bit sets.
REQ-022 If DIGIT_EN[SEL] clears during SHOW, the FSM SHALL abort to BLANK on the next cycle, with the prescaler cleared and SEL advanced per REQ-017.
REQ-023 AN and CNT SHALL change only in the same cycle as the state register; the lit-to-lit latency is exactly BLANK_CYC cycles of all-off.

Reset
REQ-024 While RST_N is 0, the block SHALL hold state=BLANK, prescaler=0, SEL=0, AN=all ones, CNT=0, FRAME_DONE=0, shadow=0, active=0.
REQ-025 Reset assertion mid-SHOW SHALL extinguish AN immediately, with no clock edge required.
REQ-026 After RST_N rises, the first lit digit SHALL be the lowest enabled index, lit BLANK_CYC cycles after the first clock edge.

Configuration
REQ-027 Macro SCAN_SELECTOR_LZB_EN SHALL, when defined, enable leading-zero blanking.
  With the macro: a digit i > 0 whose active value is 0 and whose higher-index enabled digits are all 0 SHALL keep AN all ones during its SHOW slot, with slot timing, SEL, and FRAME_DONE unchanged; digit 0 is always lit.
  Without the macro: every enabled digit SHALL be lit with no zero suppression.

Structure
REQ-028 Package scan_pkg SHALL hold the state enum type (BLANK, SHOW), the default parameter constants, and the next-enabled-index function.
REQ-029 The prescaler SHALL be implemented as sub-module scan_prescaler, with a terminal-count output and synchronous clear.

Verification (NUM_DIGITS=4, DIGIT_W=4, SCAN_DIV=4, BLANK_CYC=1 unless stated)
REQ-030 Basic scan: CNT_BUS=16'h4321, DIGIT_EN=4'hF, LOAD pulse -> after the first FRAME_DONE, the sequence SHALL be AN=1110/CNT=1, 1101/2, 1011/3, 0111/4, each lit for 4 cycles with 1 blank cycle between, and FRAME_DONE SHALL pulse every 20 cycles.
REQ-031 Skip and abort: DIGIT_EN=4'b0101 -> SEL SHALL sequence 0,2,0; clearing bit 2 while SEL=2 SHALL force AN=1111 the next cycle and then light digit 0.
REQ-032 No tearing: LOAD with 16'h9999 mid-frame -> CNT SHALL keep showing the old values until FRAME_DONE, and SHALL show 9 for all digits thereafter; LOAD coinciding with FRAME_DONE SHALL be displayed one frame later.
REQ-033 All disabled and reset: DIGIT_EN=0 for 50 cycles -> AN SHALL stay 1111 with FRAME_DONE=0; RST_N dropped mid-SHOW -> AN SHALL be 1111 and CNT 0 combinationally.
REQ-034 LZB (with the macro): CNT_BUS=16'h0050 -> AN SHALL stay 1111 in slots 3 and 2, and digits 1 and 0 SHALL light with values 5 and 0; without the macro, all four digits SHALL light.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared state type, default parameters and the enabled-digit search used by the scan selector.
package scan_pkg;

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_e;

    localparam int DEF_NUM_DIGITS = 4;
    localparam int DEF_DIGIT_W    = 4;
    localparam int DEF_SCAN_DIV   = 50000;
    localparam int DEF_BLANK_CYC  = 8;
    localparam int MAX_DIGITS     = 8;

    // First index above cur (mod n) with its enable set; cur itself if it is the only one or none are set.
    function automatic logic [2:0] next_enabled(input logic [MAX_DIGITS-1:0] en,
                                                input logic [2:0]            cur,
                                                input int                    n);
        logic [2:0] result;
        logic [2:0] pos;
        logic       found;
        result = cur;
        found  = 1'b0;
        for (int k = 1; k <= MAX_DIGITS; k++) begin
            pos = 3'((int'(cur) + k) % n);
            if (k <= n && !found && en[pos]) begin
                result = pos;
                found  = 1'b1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Slot timer for the scan selector: counts 0..limit-1, flags the last count, clears synchronously.
module scan_prescaler #(
    parameter int CNT_W = 16
) (
    input  logic             clk_sys,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [CNT_W-1:0] limit,
    output logic             tc
);

    logic [CNT_W-1:0] count_q;

    assign tc = (count_q == limit - CNT_W'(1));

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr || tc) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/scan_selector.sv
// Multiplexed digit scanner with blanking gaps and frame-synchronous data update.
// Define SCAN_SELECTOR_LZB_EN to blank leading-zero digits.
//
// state | meaning
// BLANK | all anodes off, prescaler times the gap before the next digit
// SHOW  | digit SEL lit, prescaler times the slot
module scan_selector
    import scan_pkg::*;
#(
    parameter int NUM_DIGITS = DEF_NUM_DIGITS,
    parameter int DIGIT_W    = DEF_DIGIT_W,
    parameter int SCAN_DIV   = DEF_SCAN_DIV,
    parameter int BLANK_CYC  = DEF_BLANK_CYC
) (
    input  logic                          S_CLK,
    input  logic                          RST_N,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] CNT_BUS,
    input  logic [NUM_DIGITS-1:0]         DIGIT_EN,
    input  logic                          LOAD,
    output logic [DIGIT_W-1:0]            CNT,
    output logic [NUM_DIGITS-1:0]         AN,
    output logic [$clog2(NUM_DIGITS)-1:0] SEL,
    output logic                          FRAME_DONE
);

    localparam int SEL_W   = $clog2(NUM_DIGITS);
    localparam int BUS_W   = NUM_DIGITS * DIGIT_W;
    localparam int PRE_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int CNT_W   = $clog2(PRE_MAX + 1);

    localparam logic [0:0] ST_BLANK = 1'(BLANK);
    localparam logic [0:0] ST_SHOW  = 1'(SHOW);

    logic [0:0]            state_q, state_d;
    logic [SEL_W-1:0]      sel_q, sel_d, sel_adv;
    logic [NUM_DIGITS-1:0] an_q, an_lit;
    logic [DIGIT_W-1:0]    cnt_q, digit_d;
    logic                  frame_done_q;
    logic [BUS_W-1:0]      shadow_q, active_q, active_d;
    logic                  any_en, cur_en, tc, pre_clr, advance, abort, wrap, lead_zero;
    logic [CNT_W-1:0]      pre_limit;

    assign any_en    = |DIGIT_EN;
    assign cur_en    = DIGIT_EN[sel_q];
    assign sel_adv   = SEL_W'(next_enabled(8'(DIGIT_EN), 3'(sel_q), NUM_DIGITS));
    assign pre_limit = (state_q == ST_SHOW) ? CNT_W'(SCAN_DIV) : CNT_W'(BLANK_CYC);
    assign pre_clr   = !any_en || abort;

    scan_prescaler #(
        .CNT_W(CNT_W)
    ) u_prescaler (
        .clk_sys(S_CLK),
        .rst_n  (RST_N),
        .clr    (pre_clr),
        .limit  (pre_limit),
        .tc     (tc)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        advance = 1'b0;
        abort   = 1'b0;
        if (!any_en) begin
            state_d = ST_BLANK;
        end else if (state_q == ST_SHOW) begin
            if (!cur_en) begin
                abort   = 1'b1;
                state_d = ST_BLANK;
                sel_d   = sel_adv;
                advance = 1'b1;
            end else if (tc) begin
                state_d = ST_BLANK;
                sel_d   = sel_adv;
                advance = 1'b1;
            end
        end else if (tc) begin
            // The digit waiting in SEL may have been disabled during the gap.
            state_d = ST_SHOW;
            if (!cur_en) begin
                sel_d   = sel_adv;
                advance = 1'b1;
            end
        end
        wrap     = advance && (sel_d <= sel_q);
        active_d = wrap ? shadow_q : active_q;
    end

    assign digit_d = active_d[int'(sel_d)*DIGIT_W +: DIGIT_W];
    assign an_lit  = ~(NUM_DIGITS'(1) << sel_d);

`ifdef SCAN_SELECTOR_LZB_EN
    always_comb begin
        lead_zero = (sel_d != '0);
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (j >= int'(sel_d) && DIGIT_EN[j] && active_d[j*DIGIT_W +: DIGIT_W] != '0) begin
                lead_zero = 1'b0;
            end
        end
    end
`else
    assign lead_zero = 1'b0;
`endif

    always_ff @(posedge S_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= ST_BLANK;
            sel_q        <= '0;
            an_q         <= '1;
            cnt_q        <= '0;
            frame_done_q <= 1'b0;
            shadow_q     <= '0;
            active_q     <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            frame_done_q <= wrap;
            active_q     <= active_d;
            if (LOAD) begin
                shadow_q <= CNT_BUS;
            end
            if (state_d != state_q) begin
                an_q <= (state_d == ST_SHOW && !lead_zero) ? an_lit : '1;
                if (state_d == ST_SHOW) begin
                    cnt_q <= digit_d;
                end
            end
        end
    end

    assign CNT        = cnt_q;
    assign AN         = an_q;
    assign SEL        = sel_q;
    assign FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_scan_selector.sv
// Self-checking bench for scan_selector: frame-level reference model plus directed abort/disable/reset steps.
module tb_scan_selector;

    localparam int ND   = 4;
    localparam int DW   = 4;
    localparam int SD   = 4;
    localparam int BC   = 1;
    localparam int SLOT = SD + BC;
`ifdef SCAN_SELECTOR_LZB_EN
    localparam bit LZB_ON = 1'b1;
`else
    localparam bit LZB_ON = 1'b0;
`endif

    logic        S_CLK    = 1'b0;
    logic        RST_N    = 1'b1;
    logic [15:0] CNT_BUS  = '0;
    logic [3:0]  DIGIT_EN = '0;
    logic        LOAD     = 1'b0;
    logic [3:0]  CNT;
    logic [3:0]  AN;
    logic [1:0]  SEL;
    logic        FRAME_DONE;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [15:0] shadow_m    = '0;

    scan_selector #(
        .NUM_DIGITS(ND),
        .DIGIT_W   (DW),
        .SCAN_DIV  (SD),
        .BLANK_CYC (BC)
    ) dut (
        .S_CLK     (S_CLK),
        .RST_N     (RST_N),
        .CNT_BUS   (CNT_BUS),
        .DIGIT_EN  (DIGIT_EN),
        .LOAD      (LOAD),
        .CNT       (CNT),
        .AN        (AN),
        .SEL       (SEL),
        .FRAME_DONE(FRAME_DONE)
    );

    always #5 S_CLK = ~S_CLK;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int n_enabled(input logic [3:0] en);
        int c = 0;
        for (int j = 0; j < ND; j++) if (en[j]) c++;
        return c;
    endfunction

    function automatic int nth_enabled(input logic [3:0] en, input int n);
        int c = 0;
        for (int j = 0; j < ND; j++) begin
            if (en[j]) begin
                if (c == n) return j;
                c++;
            end
        end
        return 0;
    endfunction

    // A nonzero-index digit is dark when it and every higher enabled digit hold zero.
    function automatic logic suppressed(input logic [15:0] data, input logic [3:0] en, input int i);
        logic z;
        z = (i > 0);
        for (int j = 0; j < ND; j++) begin
            if (j >= i && en[j] && data[j*DW +: DW] != 4'h0) z = 1'b0;
        end
        return LZB_ON && z;
    endfunction

    task automatic wait_frame(input string tag);
        int n = 0;
        do begin
            @(negedge S_CLK);
            n++;
        end while (FRAME_DONE !== 1'b1 && n < 400);
        check(tag, 16'(FRAME_DONE), 16'd1);
    endtask

    task automatic wait_lit(input string tag, input logic [3:0] want);
        int n = 0;
        while (AN !== want && n < 200) begin
            @(negedge S_CLK);
            n++;
        end
        check(tag, 16'(AN), 16'(want));
    endtask

    // Three frames after a sync: frame 1 shows the old shadow, a is loaded mid-frame 1,
    // b is loaded in the FRAME_DONE cycle opening frame 2 and must appear only in frame 3.
    task automatic run_trial(input logic [3:0] en, input logic [15:0] a, input logic [15:0] b);
        int          period, kk, slot, ph, i;
        logic [15:0] data;
        logic [3:0]  exp_an;
        @(negedge S_CLK);
        DIGIT_EN = en;
        wait_frame("sync0");
        wait_frame("sync1");
        period = n_enabled(en) * SLOT;
        for (int k = 0; k < 3 * period; k++) begin
            if (k > 0) @(negedge S_CLK);
            data = (k < period) ? shadow_m : (k < 2 * period) ? a : b;
            kk   = k % period;
            slot = kk / SLOT;
            ph   = kk % SLOT;
            i    = nth_enabled(en, slot);
            check("frame_done", 16'(FRAME_DONE), 16'(kk == 0));
            check("sel", 16'(SEL), 16'(i));
            if (ph < BC) begin
                check("an_blank", 16'(AN), 16'h000F);
            end else begin
                exp_an = suppressed(data, en, i) ? 4'hF : ~(4'b0001 << i);
                check("an_lit", 16'(AN), 16'(exp_an));
                check("cnt", 16'(CNT), 16'(data[i*DW +: DW]));
            end
            LOAD    = (k == period / 2) || (k == period);
            CNT_BUS = (k < period) ? a : b;
        end
        shadow_m = b;
    endtask

    initial begin
        #1 RST_N = 1'b0;
        #11;
        check("rst_an", 16'(AN), 16'h000F);
        check("rst_cnt", 16'(CNT), 16'h0000);
        check("rst_sel", 16'(SEL), 16'h0000);
        check("rst_fd", 16'(FRAME_DONE), 16'h0000);
        @(negedge S_CLK);
        RST_N = 1'b1;

        run_trial(4'hF, 16'h4321, 16'h9999);
        run_trial(4'b0101, 16'h8642, 16'h1357);
        run_trial(4'hF, 16'h0050, 16'h0A00);
        run_trial(4'b1000, 16'h7000, 16'h0000);
        run_trial(4'b1101, 16'h0050, 16'h0003);
        for (int t = 0; t < 6; t++) begin
            run_trial(4'($urandom_range(1, 15)), 16'($urandom), 16'($urandom));
        end
        run_trial(4'b0101, 16'h0321, 16'h0321);

        // Abort: drop digit 2 on its first lit cycle.
        wait_lit("abort_lit2", 4'b1011);
        DIGIT_EN = 4'b0001;
        @(negedge S_CLK);
        check("abort_an", 16'(AN), 16'h000F);
        check("abort_sel", 16'(SEL), 16'h0000);
        check("abort_fd", 16'(FRAME_DONE), 16'h0001);
        @(negedge S_CLK);
        check("abort_relit_an", 16'(AN), 16'h000E);
        check("abort_relit_cnt", 16'(CNT), 16'h0001);

        // All digits disabled.
        DIGIT_EN = 4'b0000;
        @(negedge S_CLK);
        for (int c = 0; c < 50; c++) begin
            @(negedge S_CLK);
            check("off_an", 16'(AN), 16'h000F);
            check("off_fd", 16'(FRAME_DONE), 16'h0000);
        end
        DIGIT_EN = 4'b0100;
        wait_lit("resume_an", 4'b1011);
        check("resume_sel", 16'(SEL), 16'h0002);
        check("resume_cnt", 16'(CNT), 16'h0003);

        // Reset while a digit is lit, between clock edges.
        DIGIT_EN = 4'b0110;
        #1 RST_N = 1'b0;
        #1;
        check("async_an", 16'(AN), 16'h000F);
        check("async_cnt", 16'(CNT), 16'h0000);
        check("async_sel", 16'(SEL), 16'h0000);
        check("async_fd", 16'(FRAME_DONE), 16'h0000);
        @(negedge S_CLK);
        RST_N = 1'b1;
        begin
            int n = 0;
            while (SEL === 2'd0 && n < 50) begin
                @(negedge S_CLK);
                n++;
            end
        end
        check("first_sel", 16'(SEL), 16'h0001);
        check("first_an", 16'(AN), suppressed(16'h0000, 4'b0110, 1) ? 16'h000F : 16'h000D);
        check("first_cnt", 16'(CNT), 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
